// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default widths for the data-memory arbiter between the CPU port and the host port.
package dmem_arb_pkg;

  localparam int unsigned ADDR_W_DEF    = 4;
  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned MAX_BURST_DEF = 4;
  localparam int unsigned CNT_W_DEF     = 16;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2
  } owner_e;

  typedef enum logic {
    RR_CPU  = 1'b0,
    RR_HOST = 1'b1
  } rr_e;

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data memory between the CPU load/store port and the host port.
// Round-robin on contention; a locking host may hold the memory for a bounded burst.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic              host_lock,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned         BURST_W   = $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  owner_e             owner_q, owner_d;
  rr_e                last_rr_q, last_rr_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               cpu_gnt;
  logic               lock_hold;
  logic               host_rd;

  // Grant decision plus next owner / round-robin / burst state.
  always_comb begin
    cpu_gnt   = 1'b0;
    host_gnt  = 1'b0;
    owner_d   = OWN_IDLE;
    last_rr_d = last_rr_q;
    burst_d   = '0;
    lock_hold = (owner_q == OWN_HOST) && host_req && host_lock &&
                ((burst_q < BURST_MAX) || !cpu_req);

    if (!reset) begin
      if (lock_hold) begin
        host_gnt = 1'b1;
      end else if (cpu_req && host_req) begin
        if (last_rr_q == RR_HOST) begin
          cpu_gnt   = 1'b1;
          last_rr_d = RR_CPU;
        end else begin
          host_gnt  = 1'b1;
          last_rr_d = RR_HOST;
        end
      end else begin
        cpu_gnt  = cpu_req;
        host_gnt = host_req;
      end
    end

    if (host_gnt) begin
      owner_d = OWN_HOST;
      if (owner_q != OWN_HOST) begin
        burst_d = BURST_W'(1);
      end else if (burst_q < BURST_MAX) begin
        burst_d = burst_q + BURST_W'(1);
      end else begin
        burst_d = burst_q;
      end
    end else if (cpu_gnt) begin
      owner_d = OWN_CPU;
    end
  end

  // Memory-side mux; idle cycles drive zeros so nothing is written.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (host_gnt) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
  end

  assign cpu_rdata = cpu_gnt ? mem_rdata : '0;
  assign cpu_stall = cpu_req && !cpu_gnt && !reset;
  assign host_rd   = host_gnt && !host_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q     <= OWN_IDLE;
      last_rr_q   <= RR_HOST;
      burst_q     <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      owner_q     <= owner_d;
      last_rr_q   <= last_rr_d;
      burst_q     <= burst_d;
      host_rvalid <= host_rd;
      if (host_rd) begin
        host_rdata <= mem_rdata;
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .clr   (reset),
    .inc   (cpu_stall),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter with a behavioural arbitration and memory model.
module tb_dmem_arbiter;

  localparam int unsigned AW        = 4;
  localparam int unsigned DW        = 8;
  localparam int unsigned MAX_BURST = 4;
  localparam int unsigned CW        = 3;
  localparam int          SAT       = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic          cpu_req, cpu_we, host_req, host_we, host_lock;
  logic [AW-1:0] cpu_addr, host_addr;
  logic [DW-1:0] cpu_wdata, host_wdata;
  logic [DW-1:0] cpu_rdata, host_rdata, mem_wdata, mem_rdata;
  logic          cpu_stall, host_gnt, host_rvalid, mem_we;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] stall_cnt;

  logic [DW-1:0] tb_mem [16];

  int checks = 0;
  int errors = 0;
  bit armed  = 0;

  // Behavioural model state
  bit          m_prev_host;
  int          m_streak;
  bit          m_host_won_tie;
  int          m_stall;
  bit          m_rvalid;
  logic [7:0]  m_mem [16];
  logic [7:0]  exp_q [$];

  dmem_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_stall   (cpu_stall),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_lock   (host_lock),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: combinational read, synchronous write
  assign mem_rdata = tb_mem[mem_addr];
  always @(posedge clk) if (mem_we === 1'b1) tb_mem[mem_addr] <= mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expected host read value whenever the DUT presents one
  always @(negedge clk) begin
    if (host_rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("host_rvalid_unexpected", 32'(host_rvalid), 32'd0);
      end else begin
        chk("host_rdata", 32'(host_rdata), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step(input bit rst, input bit creq, input bit cwe, input int caddr,
                      input int cwd, input bit hreq, input bit hwe, input bit hlock,
                      input int haddr, input int hwd);
    bit gc, gh, keep;
    int e_we, e_addr, e_wd, e_rd;
    @(posedge clk);
    #1;
    reset = rst; cpu_req = creq; cpu_we = cwe; cpu_addr = 4'(caddr); cpu_wdata = 8'(cwd);
    host_req = hreq; host_we = hwe; host_lock = hlock; host_addr = 4'(haddr);
    host_wdata = 8'(hwd);
    #1;
    gc = 1'b0; gh = 1'b0;
    if (!rst) begin
      keep = m_prev_host && hreq && hlock && (m_streak < MAX_BURST || !creq);
      if (keep) gh = 1'b1;
      else if (creq && hreq) begin
        gh = !m_host_won_tie;
        gc = !gh;
        m_host_won_tie = gh;
      end else begin
        gc = creq;
        gh = hreq;
      end
    end
    e_we = 0; e_addr = 0; e_wd = 0;
    if (gc) begin e_we = int'(cwe); e_addr = caddr; e_wd = cwd; end
    if (gh) begin e_we = int'(hwe); e_addr = haddr; e_wd = hwd; end
    e_rd = gc ? int'(m_mem[caddr]) : 0;
    if (armed) begin
      chk("host_gnt", 32'(host_gnt), 32'(gh));
      chk("cpu_stall", 32'(cpu_stall), 32'(creq && !gc && !rst));
      chk("cpu_rdata", 32'(cpu_rdata), 32'(e_rd));
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      chk("host_rvalid", 32'(host_rvalid), 32'(m_rvalid));
    end
    if (gh && !hwe) exp_q.push_back(m_mem[haddr]);
    if (e_we != 0) m_mem[e_addr] = 8'(e_wd);
    if (rst) begin
      m_prev_host = 0; m_streak = 0; m_host_won_tie = 1; m_stall = 0; m_rvalid = 0;
    end else begin
      m_rvalid = gh && !hwe;
      if (creq && !gc) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
      if (gh) m_streak = m_prev_host ? ((m_streak < MAX_BURST) ? m_streak + 1 : MAX_BURST) : 1;
      else m_streak = 0;
      m_prev_host = gh;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      tb_mem[i] = '0;
      m_mem[i]  = '0;
    end
    reset = 1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 0; host_we = 0; host_lock = 0; host_addr = '0; host_wdata = '0;
    m_prev_host = 0; m_streak = 0; m_host_won_tie = 1; m_stall = 0; m_rvalid = 0;

    do_reset();
    armed = 1;
    do_reset();
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset_rvalid", 32'(host_rvalid), 32'd0);

    // CPU store then load
    step(0, 1, 1, 3, 'hA5, 0, 0, 0, 0, 0);
    chk("t1_mem_we", 32'(mem_we), 32'd1);
    step(0, 1, 0, 3, 0, 0, 0, 0, 0, 0);
    chk("t1_cpu_rdata", 32'(cpu_rdata), 32'hA5);
    chk("t1_cpu_stall", 32'(cpu_stall), 32'd0);

    // Host write then read back
    step(0, 0, 0, 0, 0, 1, 1, 0, 7, 'h3C);
    chk("t2_wr_gnt", 32'(host_gnt), 32'd1);
    step(0, 0, 0, 0, 0, 1, 0, 0, 7, 0);
    chk("t2_rd_gnt", 32'(host_gnt), 32'd1);
    idle();
    chk("t2_rvalid", 32'(host_rvalid), 32'd1);
    chk("t2_rdata", 32'(host_rdata), 32'h3C);

    // Ties after reset: CPU first, then host
    do_reset();
    step(0, 1, 0, 0, 0, 1, 0, 0, 1, 0);
    chk("t3_tie1_host_gnt", 32'(host_gnt), 32'd0);
    chk("t3_tie1_stall", 32'(cpu_stall), 32'd0);
    step(0, 1, 0, 0, 0, 1, 0, 0, 1, 0);
    chk("t3_tie2_host_gnt", 32'(host_gnt), 32'd1);
    chk("t3_tie2_stall", 32'(cpu_stall), 32'd1);
    idle();
    chk("t3_stall_cnt", 32'(stall_cnt), 32'd1);

    // Locked burst bounded by MAX_BURST while the CPU waits
    do_reset();
    step(0, 1, 0, 0, 0, 1, 0, 0, 2, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0, 0, 1, 0, 1, 2, 0);
      chk("t4_burst_host_gnt", 32'(host_gnt), 32'd1);
    end
    step(0, 1, 0, 0, 0, 1, 0, 1, 2, 0);
    chk("t4_cycle5_host_gnt", 32'(host_gnt), 32'd0);
    chk("t4_cycle5_stall", 32'(cpu_stall), 32'd0);
    idle();
    chk("t4_stall_cnt", 32'(stall_cnt), 32'd4);

    // Reset in the middle of a locked host write burst
    do_reset();
    step(0, 0, 0, 0, 0, 1, 1, 1, 9, 'h11);
    chk("t5_first_gnt", 32'(host_gnt), 32'd1);
    step(1, 0, 0, 0, 0, 1, 1, 1, 10, 'h22);
    chk("t5_rst_mem_we", 32'(mem_we), 32'd0);
    chk("t5_rst_host_gnt", 32'(host_gnt), 32'd0);
    step(0, 1, 0, 10, 0, 0, 0, 0, 0, 0);
    chk("t5_mem_unchanged", 32'(cpu_rdata), 32'd0);
    chk("t5_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("t5_rvalid", 32'(host_rvalid), 32'd0);
    chk("t5_rdata", 32'(host_rdata), 32'd0);

    // Saturation of the stall counter
    do_reset();
    for (int i = 0; i < 20; i++) step(0, 1, 0, 5, 0, 1, 0, 0, 6, 0);
    idle();
    chk("t6_stall_sat", 32'(stall_cnt), 32'(SAT));

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 63) == 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
           $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
    end
    idle();
    idle();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
